// File: rtl/rank_table_drainer.sv
// Drains a DEPTH-entry table in one ascending pass, handing each entry whose
// bit 0 is set to a downstream valid/ready port and counting accepted entries.
module rank_table_drainer #(
  parameter int WIDTH    = 16,
  parameter int ADDWIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  output logic                readEnable,
  output logic [ADDWIDTH-1:0] source,
  input  logic [WIDTH-1:0]    dataOut,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [ADDWIDTH-1:0] out_addr,
  output logic                busy,
  output logic                done,
  output logic [ADDWIDTH:0]   sent_count
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    SEND,
    DONE
  } state_t;

  localparam logic [ADDWIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDWIDTH-1:0] ADDR_ONE  = 1;
  localparam logic [ADDWIDTH:0]   COUNT_ONE = 1;

  state_t              state_q;
  logic [ADDWIDTH-1:0] addr_q;
  logic [ADDWIDTH-1:0] addr_d;
  logic                rdEn_q;
  logic                valid_q;
  logic [WIDTH-1:0]    data_q;
  logic [ADDWIDTH-1:0] outAddr_q;
  logic                busy_q;
  logic                done_q;
  logic [ADDWIDTH:0]   count_q;
  logic [ADDWIDTH:0]   count_d;
  logic                lastAddr;

  always_comb begin
    addr_d   = addr_q + ADDR_ONE;
    count_d  = count_q + COUNT_ONE;
    lastAddr = (addr_q == LAST_ADDR);
  end

  // Every output is a register set on the transition into the state that owns it,
  // so readEnable is high exactly in READ and done exactly in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rdEn_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      outAddr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      rdEn_q <= 1'b0;
      done_q <= 1'b0;
      if (abort && (state_q != IDLE)) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              addr_q  <= '0;
              count_q <= '0;
              rdEn_q  <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= READ;
            end
          end
          READ: begin
            state_q <= CAPTURE;
          end
          CAPTURE: begin
            if (dataOut[0]) begin
              data_q    <= dataOut;
              outAddr_q <= addr_q;
              valid_q   <= 1'b1;
              state_q   <= SEND;
            end else if (lastAddr) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              addr_q  <= addr_d;
              rdEn_q  <= 1'b1;
              state_q <= READ;
            end
          end
          SEND: begin
            if (out_ready) begin
              valid_q <= 1'b0;
              count_q <= count_d;
              if (lastAddr) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                addr_q  <= addr_d;
                rdEn_q  <= 1'b1;
                state_q <= READ;
              end
            end
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign readEnable = rdEn_q;
  assign source     = addr_q;
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_addr   = outAddr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sent_count = count_q;

endmodule

// File: tb/tb_rank_table_drainer.sv
// Bench for rank_table_drainer: a table with registered read feeds the DUT and
// every cycle of a pass is compared with a timeline derived from the table contents.
module tb_rank_table_drainer;

  localparam int W     = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int MAXC  = 96;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          readEnable;
  logic [AW-1:0] source;
  logic [W-1:0]  dataOut;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;
  logic [AW:0]   sent_count;

  logic [W-1:0] mem [DEPTH];
  int           stalls [DEPTH];

  bit expRe [MAXC];
  int expSrc [MAXC];
  bit expValid [MAXC];
  int expData [MAXC];
  int expAddr [MAXC];
  bit expBusy [MAXC];
  bit expDone [MAXC];
  int expCount [MAXC];
  bit drvReady [MAXC];
  int lastCycle;

  int total = 0;
  int bad = 0;
  int doneSeen;

  rank_table_drainer #(.WIDTH(W), .ADDWIDTH(AW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .readEnable(readEnable),
    .source(source),
    .dataOut(dataOut),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_addr(out_addr),
    .busy(busy),
    .done(done),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  // Table with one-cycle registered read that returns zero when not strobed.
  always @(posedge clk) begin
    dataOut <= readEnable ? mem[source] : '0;
  end

  task automatic checkOutput(input string tag, input int cyc, input logic [31:0] obs,
                             input logic [31:0] want);
    total++;
    assert (obs === want)
    else begin
      bad++;
      $error("[TB] FAIL %s cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, want);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit ab, input bit rdy, input bit rst);
    start     = st;
    abort     = ab;
    out_ready = rdy;
    reset     = rst;
  endtask

  task automatic setCycle(input int t, input bit re, input int src, input bit v,
                          input int d, input int ad, input bit b, input bit dn,
                          input int cnt, input bit rdy);
    expRe[t]    = re;
    expSrc[t]   = src;
    expValid[t] = v;
    expData[t]  = d;
    expAddr[t]  = ad;
    expBusy[t]  = b;
    expDone[t]  = dn;
    expCount[t] = cnt;
    drvReady[t] = rdy;
  endtask

  // Timeline of a pass: each address costs a read and a capture cycle, and a
  // valid entry adds one send cycle per stall plus the accepting cycle.
  task automatic buildSchedule();
    int t = 1;
    int cnt = 0;
    for (int a = 0; a < DEPTH; a++) begin
      setCycle(t, 1'b1, a, 1'b0, 0, 0, 1'b1, 1'b0, cnt, 1'($urandom_range(0, 1)));
      t++;
      setCycle(t, 1'b0, a, 1'b0, 0, 0, 1'b1, 1'b0, cnt, 1'($urandom_range(0, 1)));
      t++;
      if (mem[a][0]) begin
        for (int k = 0; k <= stalls[a]; k++) begin
          setCycle(t, 1'b0, a, 1'b1, int'(mem[a]), a, 1'b1, 1'b0, cnt, k == stalls[a]);
          t++;
        end
        cnt++;
      end
    end
    setCycle(t, 1'b0, DEPTH - 1, 1'b0, 0, 0, 1'b1, 1'b1, cnt, 1'($urandom_range(0, 1)));
    t++;
    setCycle(t, 1'b0, DEPTH - 1, 1'b0, 0, 0, 1'b0, 1'b0, cnt, 1'b0);
    lastCycle = t;
  endtask

  task automatic clearTable();
    for (int a = 0; a < DEPTH; a++) begin
      mem[a]    = W'($urandom_range(0, 127) * 2);
      stalls[a] = 0;
    end
  endtask

  task automatic checkResetState(input string tag, input int cyc);
    checkOutput({tag, ".readEnable"}, cyc, 32'(readEnable), 32'd0);
    checkOutput({tag, ".source"}, cyc, 32'(source), 32'd0);
    checkOutput({tag, ".out_valid"}, cyc, 32'(out_valid), 32'd0);
    checkOutput({tag, ".out_data"}, cyc, 32'(out_data), 32'd0);
    checkOutput({tag, ".out_addr"}, cyc, 32'(out_addr), 32'd0);
    checkOutput({tag, ".busy"}, cyc, 32'(busy), 32'd0);
    checkOutput({tag, ".done"}, cyc, 32'(done), 32'd0);
    checkOutput({tag, ".sent_count"}, cyc, 32'(sent_count), 32'd0);
  endtask

  task automatic runPass(input int abortAt, input int resetAt, input int startAt);
    doneSeen = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    for (int c = 1; c <= lastCycle; c++) begin
      checkOutput("readEnable", c, 32'(readEnable), 32'(expRe[c]));
      checkOutput("source", c, 32'(source), 32'(expSrc[c]));
      checkOutput("out_valid", c, 32'(out_valid), 32'(expValid[c]));
      checkOutput("busy", c, 32'(busy), 32'(expBusy[c]));
      checkOutput("done", c, 32'(done), 32'(expDone[c]));
      checkOutput("sent_count", c, 32'(sent_count), 32'(expCount[c]));
      if (expValid[c]) begin
        checkOutput("out_data", c, 32'(out_data), 32'(expData[c]));
        checkOutput("out_addr", c, 32'(out_addr), 32'(expAddr[c]));
      end
      if (done === 1'b1) doneSeen = c;
      if (c == abortAt) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      else if (c == resetAt) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      else applyStimulus(c == startAt, 1'b0, drvReady[c], 1'b0);
      @(negedge clk);
      if (c == abortAt) begin
        for (int k = 1; k <= 3; k++) begin
          checkOutput("abort.busy", c + k, 32'(busy), 32'd0);
          checkOutput("abort.out_valid", c + k, 32'(out_valid), 32'd0);
          checkOutput("abort.done", c + k, 32'(done), 32'd0);
          checkOutput("abort.readEnable", c + k, 32'(readEnable), 32'd0);
          checkOutput("abort.sent_count", c + k, 32'(sent_count), 32'(expCount[c]));
          applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
          @(negedge clk);
        end
        return;
      end
      if (c == resetAt) begin
        checkResetState("midReset", c + 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkResetState("afterReset", c + 2);
        return;
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    clearTable();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkResetState("powerOnReset", 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("abortInIdle.busy", 0, 32'(busy), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("startWithAbort.busy", 0, 32'(busy), 32'd0);
    checkOutput("startWithAbort.readEnable", 0, 32'(readEnable), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] empty table pass with stray start");
    clearTable();
    buildSchedule();
    runPass(0, 0, 5);
    checkOutput("emptyDoneCycle", 0, 32'(doneSeen), 32'd17);

    $display("[TB] two entries, always ready");
    clearTable();
    mem[2] = 8'h35;
    mem[7] = 8'hA1;
    buildSchedule();
    runPass(0, 0, 0);
    checkOutput("twoEntryDoneCycle", 0, 32'(doneSeen), 32'd19);
    checkOutput("twoEntryCount", 0, 32'(sent_count), 32'd2);

    $display("[TB] stalled entry at address 0");
    clearTable();
    mem[0]    = 8'h0F;
    stalls[0] = 5;
    buildSchedule();
    runPass(0, 0, 4);
    checkOutput("stallDoneCycle", 0, 32'(doneSeen), 32'd23);

    $display("[TB] abort together with out_ready");
    clearTable();
    mem[1]    = 8'h55;
    mem[3]    = 8'h11;
    stalls[3] = 6;
    buildSchedule();
    runPass(12, 0, 0);
    stalls[3] = 0;
    buildSchedule();
    runPass(0, 0, 0);
    checkOutput("rescanCount", 0, 32'(sent_count), 32'd2);

    $display("[TB] reset during send");
    clearTable();
    mem[4]    = 8'h4D;
    stalls[4] = 4;
    buildSchedule();
    runPass(0, 13, 0);

    $display("[TB] randomized passes");
    for (int p = 0; p < 6; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a]    = W'($urandom_range(0, 255));
        stalls[a] = $urandom_range(0, 3);
      end
      buildSchedule();
      runPass(0, 0, $urandom_range(2, lastCycle - 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rank_table_drainer.md
RANK_TABLE_DRAINER -- requirements
Module: rank_table_drainer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning table entry width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter ADDWIDTH, default 4, meaning table address width; DEPTH = 2**ADDWIDTH entries.
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a drain pass.
REQ-006 SHALL have port abort  input  1  synchronous cancel of the current pass.
REQ-007 SHALL have port readEnable  output  1  table read strobe.
REQ-008 SHALL have port source  output  ADDWIDTH  table read address.
REQ-009 SHALL have port dataOut  input  WIDTH  table read data, valid one cycle after readEnable, bit 0 = entry-valid flag.
REQ-010 SHALL have port out_valid  output  1  emitted entry available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the emitted entry.
REQ-012 SHALL have port out_data  output  WIDTH  emitted entry contents.
REQ-013 SHALL have port out_addr  output  ADDWIDTH  table address of the emitted entry.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at pass completion.
REQ-016 SHALL have port sent_count  output  ADDWIDTH+1  number of entries accepted downstream in the current/last pass.

Function
REQ-017 SHALL implement states IDLE, READ, CAPTURE, SEND, DONE.
REQ-018 IDLE: on start=1 SHALL load addr=0, clear sent_count, go to READ; start in any other state SHALL be ignored.
REQ-019 READ: readEnable SHALL be 1 and source SHALL equal addr for exactly this one cycle; next state CAPTURE.
REQ-020 readEnable SHALL be 0 in every state other than READ; source SHALL hold addr in all states.
REQ-021 CAPTURE: if dataOut[0]=1 SHALL register out_data=dataOut, out_addr=addr, out_valid=1, go to SEND.
REQ-022 CAPTURE with dataOut[0]=0 (empty entry) SHALL emit nothing; if addr=DEPTH-1 go to DONE, else addr+1 and go to READ.
REQ-023 SEND: out_valid, out_data, out_addr SHALL remain stable until the cycle out_ready=1.
REQ-024 SEND with out_ready=1: out_valid SHALL drop next cycle, sent_count SHALL increment by 1, then DONE if addr=DEPTH-1 else addr+1 and READ.
REQ-025 Address SHALL never wrap: a pass visits addresses 0..DEPTH-1 exactly once, in ascending order.
REQ-026 DONE: done=1 for that single cycle, busy=1; next state IDLE; sent_count SHALL hold its value until the next start.
REQ-027 Pass latency with all entries empty SHALL be 2*DEPTH cycles from start cycle to done cycle inclusive of neither, i.e. done asserts in cycle 2*DEPTH+1 after start.
REQ-028 Each valid entry SHALL add 1 cycle plus out_ready stall cycles to the pass.
REQ-029 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, clear out_valid, no done pulse, sent_count retained; abort SHALL take priority over out_ready in the same cycle (entry not counted).
REQ-030 abort in IDLE SHALL have no effect; start and abort together in IDLE SHALL be treated as abort (stay IDLE).
REQ-031 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-032 reset=1 SHALL, at the next clk edge, force state IDLE, addr=0, readEnable=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0, sent_count=0.
REQ-033 reset SHALL override start, abort and out_ready, including mid-pass and mid-SEND.

Verification (ADDWIDTH=3, WIDTH=8, table model with 1-cycle registered read returning 0 when readEnable=0)
REQ-034 Empty table, start pulse -> readEnable pulses at addrs 0..7 every 2 cycles, out_valid never 1, done at cycle 17 after start, sent_count=0.
REQ-035 Entries addr2=0x35, addr7=0xA1, out_ready=1 -> emits (0x35,2) then (0xA1,7), each out_valid 1 cycle, sent_count=2, done follows addr7 acceptance.
REQ-036 addr0=0x0F, out_ready held 0 for 5 cycles -> out_valid/out_data=0x0F/out_addr=0 stable for 6 cycles, no further readEnable until accepted.
REQ-037 Entry addr3=0x11 in SEND, abort and out_ready same cycle -> IDLE next cycle, out_valid=0, no done, sent_count unchanged; new start rescans from addr 0.
REQ-038 reset asserted during SEND of addr4 -> all outputs at reset values next cycle; start pulse while busy ignored with no state change.
